fwd_hazard_unit: RTL and testbench
==================================

// Module: fwd_hazard_unit
// PURPOSE
//  Generalised operand-forwarding and hazard unit for the ID/EX boundary of the pipelined core.
//  - Selects a bypass source per operand from NUM_STG downstream stages.
//  - Tracks in-flight multi-cycle producers (load, multiplier) in a per-register countdown scoreboard.
//  - Raises stall on load-use, scoreboard, WAW and no-forwarding hazards.
// PARAMETERS
//  REG_AW   4  register address width; 2**REG_AW architectural registers
//  NUM_SRC  3  source operands per instruction
//  NUM_STG  2  forwarding stages; index 0 = youngest (EX/MEM), NUM_STG-1 = oldest (WB)
//  MAX_LAT  4  max producer latency in cycles; CNT_W = $clog2(MAX_LAT+1)
//  SEL_W    derived = $clog2(NUM_STG+1); width of each select field
// PORTS
//  clk           in   1                 clock, rising edge
//  rst_n         in   1                 asynchronous, active-low reset
//  forwarding    in   1                 1 = bypass enabled; 0 = stall-only mode
//  src_valid     in   NUM_SRC           operand i is actually read
//  src_addr      in   NUM_SRC*REG_AW    operand i register, packed, i=0 at LSBs
//  stg_wb_en     in   NUM_STG           stage k will write a register
//  stg_wb_dest   in   NUM_STG*REG_AW    stage k destination, packed
//  stg_ready     in   NUM_STG           stage k result is forwardable now (0 = load still in MEM)
//  issue_valid   in   1                 instruction in ID wants to issue
//  issue_wb_en   in   1                 issuing instruction writes issue_dest
//  issue_dest    in   REG_AW            destination of issuing instruction
//  issue_lat     in   CNT_W             cycles until result is on a forwarding stage; 0 = single-cycle ALU
//  flush         in   1                 pipeline flush (branch taken / exception)
//  sel_src       out  NUM_SRC*SEL_W     per-operand mux select: 0 = regfile, k+1 = stage k
//  stall         out  1                 hold IF/ID, bubble into EX
//  busy_mask     out  2**REG_AW         bit r = scoreboard count[r] != 0
//  stall_cnt     out  16                saturating count of stalled cycles (perf counter)
// BEHAVIOUR
//  Reset: all scoreboard counters = 0, stall_cnt = 0.
//   Outputs during reset: sel_src = 0, busy_mask = 0; stall is 1 only if a stage hazard is present.
//  sel_src, stall and busy_mask are combinational from inputs + state (0-cycle latency).
//   Scoreboard and stall_cnt update on the clock edge.
//  Per operand i with src_valid[i] (invalid operand -> sel 0, no hazard):
//   - forwarding=1: youngest stage k with stg_wb_en[k] && dest==src_addr[i] wins.
//     stg_ready[k]=1 -> sel=k+1; stg_ready[k]=0 -> sel=k+1 and hazard (load-use).
//   - forwarding=0: sel=0; any stage match -> hazard.
//   - count[src_addr[i]] != 0 -> hazard, regardless of stage match.
//  WAW: issue_valid && issue_wb_en && count[issue_dest] != 0 -> hazard.
//  stall = issue_valid && any hazard.
//  accept = issue_valid && !stall && !flush.
//  Scoreboard per register r, each cycle, priority top-down:
//   - flush: count[r] <= 0 (all registers).
//   - accept && issue_wb_en && issue_dest==r && issue_lat!=0: count[r] <= issue_lat.
//   - count[r] != 0: count[r] <= count[r]-1.
//  Boundaries:
//   - issue_lat > MAX_LAT is clamped to MAX_LAT.
//   - count==1 still stalls in that cycle; dependant issues next cycle via stage forward.
//   - flush with stall asserted: flush wins, no scoreboard set.
//   - stall_cnt increments when stall && !flush and saturates at 16'hFFFF.
//   - rst_n low mid-operation clears all state immediately.
// STRUCTURE
//  Shared package fwd_pkg: SEL_RF=0 constant, SEL_W/CNT_W functions, sel encoding helper.
//  Sub-module fwd_src_sel: one operand's stage-priority match -> {sel, hazard}; instantiated NUM_SRC times via generate.
//  Scoreboard counters and stall_cnt live in the top.
// TESTING
//  1. fwd=1, stg0 wb r3 ready, stg1 wb r3, src0=r3 -> sel_src[0]=1 (youngest wins), stall=0.
//  2. fwd=1, stg0 wb r5, stg_ready[0]=0, src1=r5 -> sel=1, stall=1. Next cycle ready=1 -> stall=0, stall_cnt=1.
//  3. Issue r7 with lat=3 -> busy_mask[7]=1 for 3 cycles. Src=r7 stalls exactly cycles 1..3, clean on cycle 4.
//  4. r2 pending (count=2), issue_dest=r2 -> WAW stall=1. flush pulse -> busy_mask=0, next cycle stall=0.
//  5. fwd=0, stg1 wb r4, src2=r4 -> sel=0, stall=1. src_valid[2]=0 -> stall=0.
//  6. Assert rst_n low with counts nonzero -> busy_mask=0, stall_cnt=0 same cycle. lat=7 with MAX_LAT=4 -> count loads 4.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the ID/EX forwarding and hazard unit:
// the register-file select code and the width/encoding helpers.
package fwd_pkg;

  // Operand mux select that reads the register file (no bypass).
  localparam int SEL_RF = 0;

  // Width of a per-operand select field for a given number of bypass stages.
  function automatic int sel_w(input int num_stg);
    return $clog2(num_stg + 1);
  endfunction

  // Width of a scoreboard countdown able to hold a latency of max_lat.
  function automatic int cnt_w(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  // Select code for bypass stage k; code 0 is reserved for the register file.
  function automatic int sel_enc(input int k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// One source operand's bypass selection: finds the youngest stage writing
// the operand's register and reports the mux select plus any hazard.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int NUM_STG = 2,
  parameter int SEL_W   = 2
) (
  input  logic                       forwarding,
  input  logic                       src_valid,
  input  logic [REG_AW-1:0]          src_addr,
  input  logic                       src_busy,
  input  logic [NUM_STG-1:0]         stg_wb_en,
  input  logic [NUM_STG*REG_AW-1:0]  stg_wb_dest,
  input  logic [NUM_STG-1:0]         stg_ready,
  output logic [SEL_W-1:0]           sel,
  output logic                       hazard
);

  logic hit;
  logic hit_rdy;
  int   hit_k;

  // Scan oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    hit     = 1'b0;
    hit_rdy = 1'b0;
    hit_k   = 0;
    sel     = SEL_W'(SEL_RF);
    hazard  = 1'b0;
    for (int k = NUM_STG - 1; k >= 0; k--) begin
      if (stg_wb_en[k] && (stg_wb_dest[k*REG_AW +: REG_AW] == src_addr)) begin
        hit     = 1'b1;
        hit_rdy = stg_ready[k];
        hit_k   = k;
      end
    end
    if (src_valid) begin
      if (forwarding) begin
        if (hit) begin
          sel    = SEL_W'(sel_enc(hit_k));
          hazard = !hit_rdy;
        end
      end else begin
        hazard = hit;
      end
      // A multi-cycle producer still in flight is not on any stage yet.
      if (src_busy) hazard = 1'b1;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ID/EX forwarding and hazard unit: per-operand bypass selection, a
// per-register countdown scoreboard for multi-cycle producers, stall
// generation and a saturating stall-cycle counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 3,
  parameter int NUM_STG = 2,
  parameter int MAX_LAT = 4,
  parameter int SEL_W   = sel_w(NUM_STG),
  parameter int CNT_W   = cnt_w(MAX_LAT)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       forwarding,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  src_addr,
  input  logic [NUM_STG-1:0]         stg_wb_en,
  input  logic [NUM_STG*REG_AW-1:0]  stg_wb_dest,
  input  logic [NUM_STG-1:0]         stg_ready,
  input  logic                       issue_valid,
  input  logic                       issue_wb_en,
  input  logic [REG_AW-1:0]          issue_dest,
  input  logic [CNT_W-1:0]           issue_lat,
  input  logic                       flush,
  output logic [NUM_SRC*SEL_W-1:0]   sel_src,
  output logic                       stall,
  output logic [2**REG_AW-1:0]       busy_mask,
  output logic [15:0]                stall_cnt
);

  localparam int NREG = 2**REG_AW;

  logic [CNT_W-1:0]         count [NREG];
  logic [NUM_SRC*SEL_W-1:0] sel_raw;
  logic [NUM_SRC-1:0]       src_hazard;
  logic                     waw_hazard;
  logic                     accept;
  logic [CNT_W-1:0]         lat_clamped;

  // Busy flag per register straight from the countdowns.
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NREG; r++) busy_mask[r] = (count[r] != '0);
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_sel #(
      .REG_AW  (REG_AW),
      .NUM_STG (NUM_STG),
      .SEL_W   (SEL_W)
    ) u_src_sel (
      .forwarding  (forwarding),
      .src_valid   (src_valid[i]),
      .src_addr    (src_addr[i*REG_AW +: REG_AW]),
      .src_busy    (busy_mask[src_addr[i*REG_AW +: REG_AW]]),
      .stg_wb_en   (stg_wb_en),
      .stg_wb_dest (stg_wb_dest),
      .stg_ready   (stg_ready),
      .sel         (sel_raw[i*SEL_W +: SEL_W]),
      .hazard      (src_hazard[i])
    );
  end

  // Combine operand and WAW hazards into stall; selects forced to regfile in reset.
  always_comb begin
    waw_hazard  = issue_valid && issue_wb_en && busy_mask[issue_dest];
    stall       = issue_valid && ((|src_hazard) || waw_hazard);
    accept      = issue_valid && !stall && !flush;
    lat_clamped = (issue_lat > CNT_W'(MAX_LAT)) ? CNT_W'(MAX_LAT) : issue_lat;
    sel_src     = rst_n ? sel_raw : '0;
  end

  // Scoreboard countdowns: flush clears, an accepted multi-cycle issue loads, otherwise count down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) count[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (flush) begin
          count[r] <= '0;
        end else if (accept && issue_wb_en && (issue_dest == REG_AW'(r)) && (issue_lat != '0)) begin
          count[r] <= lat_clamped;
        end else if (count[r] != '0) begin
          count[r] <= count[r] - 1'b1;
        end
      end
    end
  end

  // Saturating count of cycles spent stalled; flushed cycles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit with hand-computed expectations.
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 4;
  localparam int NUM_SRC = 3;
  localparam int NUM_STG = 2;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 3;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      forwarding;
  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*REG_AW-1:0] src_addr;
  logic [NUM_STG-1:0]        stg_wb_en;
  logic [NUM_STG*REG_AW-1:0] stg_wb_dest;
  logic [NUM_STG-1:0]        stg_ready;
  logic                      issue_valid;
  logic                      issue_wb_en;
  logic [REG_AW-1:0]         issue_dest;
  logic [CNT_W-1:0]          issue_lat;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  sel_src;
  logic                      stall;
  logic [15:0]               busy_mask;
  logic [15:0]               stall_cnt;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .forwarding  (forwarding),
    .src_valid   (src_valid),
    .src_addr    (src_addr),
    .stg_wb_en   (stg_wb_en),
    .stg_wb_dest (stg_wb_dest),
    .stg_ready   (stg_ready),
    .issue_valid (issue_valid),
    .issue_wb_en (issue_wb_en),
    .issue_dest  (issue_dest),
    .issue_lat   (issue_lat),
    .flush       (flush),
    .sel_src     (sel_src),
    .stall       (stall),
    .busy_mask   (busy_mask),
    .stall_cnt   (stall_cnt)
  );

  task automatic idle();
    forwarding  = 1'b1;
    src_valid   = '0;
    src_addr    = '0;
    stg_wb_en   = '0;
    stg_wb_dest = '0;
    stg_ready   = '1;
    issue_valid = 1'b0;
    issue_wb_en = 1'b0;
    issue_dest  = '0;
    issue_lat   = '0;
    flush       = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    // stage hazard-free match present during reset: select must still read regfile
    stg_wb_en   = 2'b01;
    stg_wb_dest = {4'd0, 4'd3};
    src_valid   = 3'b001;
    src_addr    = {4'd0, 4'd0, 4'd3};
    issue_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (sel_src !== 6'd0) begin errors++; $display("FAIL reset_sel got=%0h exp=0", sel_src); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    vectors++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL reset_busy got=%0h exp=0", busy_mask); end
    vectors++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    // a not-ready stage match is a hazard even in reset
    stg_ready = 2'b00;
    #1;
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stage_haz got=%0b exp=1", stall); end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_youngest();
    idle();
    stg_wb_en   = 2'b11;
    stg_wb_dest = {4'd3, 4'd3};
    stg_ready   = 2'b11;
    src_valid   = 3'b001;
    src_addr    = {4'd0, 4'd0, 4'd3};
    issue_valid = 1'b1;
    #1;
    vectors++; if (sel_src !== 6'b000001) begin errors++; $display("FAIL youngest_sel got=%b exp=000001", sel_src); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL youngest_stall got=%0b exp=0", stall); end
    // only the oldest stage matches, on operand 2; operand 0 misses
    stg_wb_dest = {4'd3, 4'd9};
    src_valid   = 3'b101;
    src_addr    = {4'd3, 4'd0, 4'd1};
    #1;
    vectors++; if (sel_src !== 6'b100000) begin errors++; $display("FAIL oldest_sel got=%b exp=100000", sel_src); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_load_use();
    idle();
    stg_wb_en   = 2'b01;
    stg_wb_dest = {4'd0, 4'd5};
    stg_ready   = 2'b00;
    src_valid   = 3'b010;
    src_addr    = {4'd0, 4'd5, 4'd0};
    issue_valid = 1'b1;
    #1;
    vectors++; if (sel_src !== 6'b000100) begin errors++; $display("FAIL loaduse_sel got=%b exp=000100", sel_src); end
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got=%0b exp=1", stall); end
    @(negedge clk);
    stg_ready = 2'b01;
    #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL loaduse_clear got=%0b exp=0", stall); end
    vectors++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL loaduse_cnt got=%0d exp=1", stall_cnt); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    issue_valid = 1'b1;
    issue_wb_en = 1'b1;
    issue_dest  = 4'd7;
    issue_lat   = 3'd3;
    @(negedge clk);
    issue_wb_en = 1'b0;
    src_valid   = 3'b001;
    src_addr    = {4'd0, 4'd0, 4'd7};
    for (int c = 1; c <= 4; c++) begin
      #1;
      vectors++;
      if (busy_mask !== ((c <= 3) ? 16'h0080 : 16'h0000)) begin
        errors++; $display("FAIL sb_busy cyc=%0d got=%0h", c, busy_mask);
      end
      vectors++;
      if (stall !== (c <= 3)) begin
        errors++; $display("FAIL sb_stall cyc=%0d got=%0b exp=%0b", c, stall, (c <= 3));
      end
      @(negedge clk);
    end
    idle();
    #1;
    vectors++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL sb_cnt got=%0d exp=4", stall_cnt); end
  endtask

  task automatic test_waw_flush();
    idle();
    issue_valid = 1'b1;
    issue_wb_en = 1'b1;
    issue_dest  = 4'd2;
    issue_lat   = 3'd2;
    @(negedge clk);
    issue_lat = 3'd1;
    #1;
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got=%0b exp=1", stall); end
    vectors++; if (busy_mask !== 16'h0004) begin errors++; $display("FAIL waw_busy got=%0h exp=0004", busy_mask); end
    @(negedge clk);
    flush = 1'b1;
    #1;
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_flush_stall got=%0b exp=1", stall); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    vectors++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL flush_busy got=%0h exp=0", busy_mask); end
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0b exp=0", stall); end
    @(negedge clk);
    idle();
    #1;
    vectors++; if (busy_mask !== 16'h0004) begin errors++; $display("FAIL waw_reissue got=%0h exp=0004", busy_mask); end
    vectors++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL waw_cnt got=%0d exp=5", stall_cnt); end
    @(negedge clk);
  endtask

  task automatic test_no_fwd();
    idle();
    forwarding  = 1'b0;
    stg_wb_en   = 2'b10;
    stg_wb_dest = {4'd4, 4'd0};
    src_valid   = 3'b100;
    src_addr    = {4'd4, 4'd0, 4'd0};
    issue_valid = 1'b1;
    #1;
    vectors++; if (sel_src !== 6'd0) begin errors++; $display("FAIL nofwd_sel got=%b exp=0", sel_src); end
    vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL nofwd_stall got=%0b exp=1", stall); end
    src_valid = 3'b000;
    #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL nofwd_invalid got=%0b exp=0", stall); end
    src_valid   = 3'b100;
    issue_valid = 1'b0;
    #1;
    vectors++; if (stall !== 1'b0) begin errors++; $display("FAIL nofwd_noissue got=%0b exp=0", stall); end
    idle();
    @(negedge clk);
  endtask

  task automatic test_clamp_and_async_reset();
    idle();
    issue_valid = 1'b1;
    issue_wb_en = 1'b1;
    issue_dest  = 4'd9;
    issue_lat   = 3'd7;
    @(negedge clk);
    issue_wb_en = 1'b0;
    src_valid   = 3'b001;
    src_addr    = {4'd0, 4'd0, 4'd9};
    for (int c = 1; c <= 5; c++) begin
      #1;
      vectors++;
      if (stall !== (c <= 4)) begin
        errors++; $display("FAIL clamp_stall cyc=%0d got=%0b exp=%0b", c, stall, (c <= 4));
      end
      @(negedge clk);
    end
    idle();
    #1;
    vectors++; if (stall_cnt !== 16'd9) begin errors++; $display("FAIL clamp_cnt got=%0d exp=9", stall_cnt); end
    issue_valid = 1'b1;
    issue_wb_en = 1'b1;
    issue_dest  = 4'd9;
    issue_lat   = 3'd2;
    @(negedge clk);
    idle();
    #1;
    vectors++; if (busy_mask !== 16'h0200) begin errors++; $display("FAIL pre_rst_busy got=%0h exp=0200", busy_mask); end
    rst_n = 1'b0;
    #1;
    vectors++; if (busy_mask !== 16'h0) begin errors++; $display("FAIL async_rst_busy got=%0h exp=0", busy_mask); end
    vectors++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_youngest();
    test_load_use();
    test_scoreboard();
    test_waw_flush();
    test_no_fwd();
    test_clamp_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
